// File: rtl/ps2_direction_decoder.sv
// PS/2 set-2 byte decoder: tracks E0/F0/E1 prefixes and arrow-key held levels,
// emitting one event per real held-state change.
module ps2_direction_decoder #(
  parameter logic [8:0] LEFT_CODE      = 9'h16B,
  parameter logic [8:0] RIGHT_CODE     = 9'h174,
  parameter logic [8:0] UP_CODE        = 9'h175,
  parameter logic [8:0] DOWN_CODE      = 9'h172,
  parameter int         PREFIX_TIMEOUT = 100000,
  parameter int         PAUSE_SKIP     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_new,
  input  logic [7:0] din,
  output logic       leftPressed,
  output logic       rightPressed,
  output logic       upPressed,
  output logic       downPressed,
  output logic       keyEvent,
  output logic [8:0] keyCode,
  output logic       keyMake
);

  localparam int TW = (PREFIX_TIMEOUT < 2) ? 1 : $clog2(PREFIX_TIMEOUT + 1);
  localparam int SW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(PREFIX_TIMEOUT);
  localparam logic [SW-1:0] SK_INIT = SW'(PAUSE_SKIP);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_SKIP    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    held_q, held_d;   // {left, right, up, down}
  logic          event_q, event_d;
  logic [8:0]    code_q, code_d;
  logic          make_q, make_d;

  logic          do_key;
  logic          key_brk;
  logic [8:0]    key_code;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    to_d     = to_q;
    held_d   = held_q;
    event_d  = 1'b0;
    code_d   = code_q;
    make_d   = make_q;
    do_key   = 1'b0;
    key_brk  = 1'b0;
    key_code = 9'h000;

    if (din_new) begin
      // A byte always wins over a timeout expiring in the same cycle.
      to_d = '0;
      case (state_q)
        S_IDLE: begin
          if (din == 8'hE0) begin
            state_d = S_EXT;
          end else if (din == 8'hF0) begin
            state_d = S_BRK;
          end else if (din == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = SK_INIT;
          end else if (din == 8'h00 || din == 8'hFF) begin
            held_d = 4'b0000;
          end else begin
            do_key   = 1'b1;
            key_code = {1'b0, din};
          end
        end
        S_EXT: begin
          if (din == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            do_key   = 1'b1;
            key_code = {1'b1, din};
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          do_key   = 1'b1;
          key_brk  = 1'b1;
          key_code = {1'b0, din};
          state_d  = S_IDLE;
        end
        S_EXT_BRK: begin
          do_key   = 1'b1;
          key_brk  = 1'b1;
          key_code = {1'b1, din};
          state_d  = S_IDLE;
        end
        S_SKIP: begin
          if (skip_q <= SW'(1)) begin
            skip_d  = '0;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (to_q == TO_MAX) begin
        state_d = S_IDLE;
        to_d    = '0;
        skip_d  = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    if (do_key) begin
      if (key_code == LEFT_CODE)  held_d[3] = ~key_brk;
      if (key_code == RIGHT_CODE) held_d[2] = ~key_brk;
      if (key_code == UP_CODE)    held_d[1] = ~key_brk;
      if (key_code == DOWN_CODE)  held_d[0] = ~key_brk;
      // Typematic repeats and breaks of released keys leave held_d unchanged.
      if (held_d != held_q) begin
        event_d = 1'b1;
        code_d  = key_code;
        make_d  = ~key_brk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      to_q    <= '0;
      held_q  <= 4'b0000;
      event_q <= 1'b0;
      code_q  <= 9'h000;
      make_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      to_q    <= to_d;
      held_q  <= held_d;
      event_q <= event_d;
      code_q  <= code_d;
      make_q  <= make_d;
    end
  end

  assign leftPressed  = held_q[3];
  assign rightPressed = held_q[2];
  assign upPressed    = held_q[1];
  assign downPressed  = held_q[0];
  assign keyEvent     = event_q;
  assign keyCode      = code_q;
  assign keyMake      = make_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Table-driven bench for ps2_direction_decoder: each row is one or more cycles of
// input with the outputs required one edge later (flags are {left,right,up,down}).
module tb_ps2_direction_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_new;
    logic [7:0] din;
    logic       left_p, right_p, up_p, down_p;
    logic       key_event;
    logic [8:0] key_code;
    logic       key_make;

    always #5 clk = ~clk;

    ps2_direction_decoder #(.PREFIX_TIMEOUT(50)) dut (
        .clk          (clk),
        .reset        (reset),
        .din_new      (din_new),
        .din          (din),
        .leftPressed  (left_p),
        .rightPressed (right_p),
        .upPressed    (up_p),
        .downPressed  (down_p),
        .keyEvent     (key_event),
        .keyCode      (key_code),
        .keyMake      (key_make)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] dat;
        int         rep;
        logic [3:0] flags;
        logic       evt;
        logic [8:0] code;
        logic       make;
    } vec_t;

    vec_t tbl[128];
    int   n_rows = 0;
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic rst, input logic vld, input logic [7:0] dat, input int rep,
                       input logic [3:0] flags, input logic evt, input logic [8:0] code,
                       input logic make);
        tbl[n_rows].rst   = rst;
        tbl[n_rows].vld   = vld;
        tbl[n_rows].dat   = dat;
        tbl[n_rows].rep   = rep;
        tbl[n_rows].flags = flags;
        tbl[n_rows].evt   = evt;
        tbl[n_rows].code  = code;
        tbl[n_rows].make  = make;
        n_rows++;
    endtask

    // Byte strobe with no reset.
    task automatic b(input logic [7:0] dat, input logic [3:0] flags, input logic evt,
                     input logic [8:0] code, input logic make);
        add(1'b0, 1'b1, dat, 1, flags, evt, code, make);
    endtask

    task automatic chk(input string tag, input logic [3:0] flags, input logic evt,
                       input logic [8:0] code, input logic make);
        tests++;
        if ({left_p, right_p, up_p, down_p} !== flags || key_event !== evt ||
            key_code !== code || key_make !== make) begin
            fails++;
            $display("FAIL %s: got flags=%b evt=%b code=%h make=%b, want flags=%b evt=%b code=%h make=%b",
                     tag, {left_p, right_p, up_p, down_p}, key_event, key_code, key_make,
                     flags, evt, code, make);
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [7:0] dat);
        reset   = rst;
        din_new = vld;
        din     = dat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        reset   = 1'b1;
        din_new = 1'b0;
        din     = 8'h00;

        // Reset state
        add(1'b1, 1'b0, 8'h00, 2, 4'h0, 1'b0, 9'h000, 1'b0);
        // Extended make, idle, extended break
        b(8'hE0, 4'h0, 0, 9'h000, 0);
        b(8'h6B, 4'h8, 1, 9'h16B, 1);
        add(1'b0, 1'b0, 8'h00, 100, 4'h8, 1'b0, 9'h16B, 1'b1);
        b(8'hE0, 4'h8, 0, 9'h16B, 1);
        b(8'hF0, 4'h8, 0, 9'h16B, 1);
        b(8'h6B, 4'h0, 1, 9'h16B, 0);
        // Typematic repeats of up: one event only
        b(8'hE0, 4'h0, 0, 9'h16B, 0);
        b(8'h75, 4'h2, 1, 9'h175, 1);
        for (int i = 0; i < 4; i++) begin
            b(8'hE0, 4'h2, 0, 9'h175, 1);
            b(8'h75, 4'h2, 0, 9'h175, 1);
        end
        // Non-extended alias make and break: no effect
        b(8'h6B, 4'h2, 0, 9'h175, 1);
        b(8'hF0, 4'h2, 0, 9'h175, 1);
        b(8'h6B, 4'h2, 0, 9'h175, 1);
        // Pause sequence swallowed, then down pressed
        b(8'hE1, 4'h2, 0, 9'h175, 1);
        b(8'h14, 4'h2, 0, 9'h175, 1);
        b(8'h77, 4'h2, 0, 9'h175, 1);
        b(8'hE1, 4'h2, 0, 9'h175, 1);
        b(8'hF0, 4'h2, 0, 9'h175, 1);
        b(8'h14, 4'h2, 0, 9'h175, 1);
        b(8'hF0, 4'h2, 0, 9'h175, 1);
        b(8'h77, 4'h2, 0, 9'h175, 1);
        b(8'hE0, 4'h2, 0, 9'h175, 1);
        b(8'h72, 4'h3, 1, 9'h172, 1);
        // Prefix timeout: 74 after 60 idle cycles is a plain make of 074
        b(8'hE0, 4'h3, 0, 9'h172, 1);
        add(1'b0, 1'b0, 8'h00, 60, 4'h3, 1'b0, 9'h172, 1'b1);
        b(8'h74, 4'h3, 0, 9'h172, 1);
        // Just inside the timeout the prefix is still honoured
        b(8'hE0, 4'h3, 0, 9'h172, 1);
        add(1'b0, 1'b0, 8'h00, 49, 4'h3, 1'b0, 9'h172, 1'b1);
        b(8'h74, 4'h7, 1, 9'h174, 1);
        // Real release of up, then break of an already released key
        b(8'hE0, 4'h7, 0, 9'h174, 1);
        b(8'hF0, 4'h7, 0, 9'h174, 1);
        b(8'h75, 4'h5, 1, 9'h175, 0);
        b(8'hE0, 4'h5, 0, 9'h175, 0);
        b(8'hF0, 4'h5, 0, 9'h175, 0);
        b(8'h75, 4'h5, 0, 9'h175, 0);
        // Unmatched extended make
        b(8'hE0, 4'h5, 0, 9'h175, 0);
        b(8'h70, 4'h5, 0, 9'h175, 0);
        // Hold left and up, then overrun clears everything silently
        b(8'hE0, 4'h5, 0, 9'h175, 0);
        b(8'h6B, 4'hD, 1, 9'h16B, 1);
        b(8'hE0, 4'hD, 0, 9'h16B, 1);
        b(8'h75, 4'hF, 1, 9'h175, 1);
        b(8'h00, 4'h0, 0, 9'h175, 1);
        b(8'hFF, 4'h0, 0, 9'h175, 1);
        // Re-press left, reset between E0 and F0
        b(8'hE0, 4'h0, 0, 9'h175, 1);
        b(8'h6B, 4'h8, 1, 9'h16B, 1);
        b(8'hE0, 4'h8, 0, 9'h16B, 1);
        add(1'b1, 1'b1, 8'hF0, 1, 4'h0, 1'b0, 9'h000, 1'b0);
        b(8'h6B, 4'h0, 0, 9'h000, 0);
        // Decoder usable again after reset
        b(8'hE0, 4'h0, 0, 9'h000, 0);
        b(8'h6B, 4'h8, 1, 9'h16B, 1);

        for (int r = 0; r < n_rows; r++) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                reset   = tbl[r].rst;
                din_new = tbl[r].vld;
                din     = tbl[r].dat;
                exp_q.push_back(tbl[r]);
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                chk($sformatf("row %0d cyc %0d", r, k), e.flags, e.evt, e.code, e.make);
            end
        end

        // Reset-state check: left is held, reset clears every output on the next edge
        drive(1'b1, 1'b0, 8'h00);
        chk("reset state", 4'h0, 1'b0, 9'h000, 1'b0);

        // Expired-wait check: E0, 60 idle cycles, then 74 is a non-extended make
        drive(1'b0, 1'b1, 8'hE0);
        repeat (60) drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h74);
        chk("expired wait", 4'h0, 1'b0, 9'h000, 1'b0);

        reset   = 1'b0;
        din_new = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
